// File: rtl/vga_pkg.sv
// Shared timing sets and derived-constant helpers for the VGA raster timing generator.
package vga_pkg;

  // 640x480@60, 25.175 MHz pixel clock
  localparam int VGA640_H_DISP = 640;
  localparam int VGA640_H_FP   = 16;
  localparam int VGA640_H_SYNC = 96;
  localparam int VGA640_H_BP   = 48;
  localparam int VGA640_V_DISP = 480;
  localparam int VGA640_V_FP   = 10;
  localparam int VGA640_V_SYNC = 2;
  localparam int VGA640_V_BP   = 33;

  // 800x600@60, 40 MHz pixel clock, positive syncs
  localparam int VGA800_H_DISP = 800;
  localparam int VGA800_H_FP   = 40;
  localparam int VGA800_H_SYNC = 128;
  localparam int VGA800_H_BP   = 88;
  localparam int VGA800_V_DISP = 600;
  localparam int VGA800_V_FP   = 1;
  localparam int VGA800_V_SYNC = 4;
  localparam int VGA800_V_BP   = 23;

  function automatic int h_total(input int disp, input int fp, input int sync, input int bp);
    return disp + fp + sync + bp;
  endfunction

  function automatic int v_total(input int disp, input int fp, input int sync, input int bp);
    return disp + fp + sync + bp;
  endfunction

  // First and last counter value of the sync pulse inside a line or frame.
  function automatic int sync_first(input int disp, input int fp);
    return disp + fp;
  endfunction

  function automatic int sync_last(input int disp, input int fp, input int sync);
    return disp + fp + sync - 1;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping counter for one raster axis; advances on carry_in_i and flags the wrap on carry_out_o.
module vga_axis_counter #(
  parameter int W     = 10,
  parameter int TOTAL = 800
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         carry_in_i,
  output logic [W-1:0] cnt_o,
  output logic         carry_out_o
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (carry_in_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o       = cnt_q;
  assign carry_out_o = carry_in_i && (cnt_q == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing: counters, region decode and one aligned output register stage.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_DISP = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_DISP = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int H_POL  = 0,
  parameter int V_POL  = 0,
  parameter int CW     = 10
) (
  input  logic          CLK_pix_rate,
  input  logic          reset,
  input  logic          pix_en,
  input  logic [CW-1:0] line_cmp,
  output logic          h_sync,
  output logic          v_sync,
  output logic          video_on,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          line_start,
  output logic          frame_start,
  output logic          line_irq
);

  localparam int H_TOTAL = h_total(H_DISP, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_DISP, V_FP, V_SYNC, V_BP);

  localparam logic [CW-1:0] H_ACT_END = CW'(H_DISP);
  localparam logic [CW-1:0] V_ACT_END = CW'(V_DISP);
  localparam logic [CW-1:0] HS_FIRST  = CW'(sync_first(H_DISP, H_FP));
  localparam logic [CW-1:0] HS_LAST   = CW'(sync_last(H_DISP, H_FP, H_SYNC));
  localparam logic [CW-1:0] VS_FIRST  = CW'(sync_first(V_DISP, V_FP));
  localparam logic [CW-1:0] VS_LAST   = CW'(sync_last(V_DISP, V_FP, V_SYNC));
  localparam logic          H_ACT     = (H_POL != 0);
  localparam logic          V_ACT     = (V_POL != 0);

  if (H_DISP < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_DISP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_region
    $fatal(1, "vga_timing_gen: every timing region must be at least one unit wide");
  end
  if (CW < 1 || CW > 30 || H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_width
    $fatal(1, "vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
  end

  logic [CW-1:0] h_cnt, v_cnt;
  logic          h_wrap, v_wrap_unused;

  vga_axis_counter #(.W(CW), .TOTAL(H_TOTAL)) u_h_cnt (
    .clk_i      (CLK_pix_rate),
    .rst_ni     (reset),
    .carry_in_i (pix_en),
    .cnt_o      (h_cnt),
    .carry_out_o(h_wrap)
  );

  vga_axis_counter #(.W(CW), .TOTAL(V_TOTAL)) u_v_cnt (
    .clk_i      (CLK_pix_rate),
    .rst_ni     (reset),
    .carry_in_i (h_wrap),
    .cnt_o      (v_cnt),
    .carry_out_o(v_wrap_unused)
  );

  logic          h_sync_d, v_sync_d, video_on_d, line_start_d, frame_start_d, line_irq_d;
  logic          h_sync_q, v_sync_q, video_on_q, line_start_q, frame_start_q, line_irq_q;
  logic [CW-1:0] pixel_x_q, pixel_y_q;

  // Decode of the current counter pair; registered below so every output names the same pixel.
  always_comb begin
    h_sync_d      = (h_cnt >= HS_FIRST && h_cnt <= HS_LAST) ? H_ACT : ~H_ACT;
    v_sync_d      = (v_cnt >= VS_FIRST && v_cnt <= VS_LAST) ? V_ACT : ~V_ACT;
    video_on_d    = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    line_start_d  = (h_cnt == '0);
    frame_start_d = (h_cnt == '0) && (v_cnt == '0);
    line_irq_d    = (h_cnt == '0) && (v_cnt == line_cmp);
  end

  always_ff @(posedge CLK_pix_rate) begin
    if (!reset) begin
      h_sync_q      <= ~H_ACT;
      v_sync_q      <= ~V_ACT;
      video_on_q    <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      line_irq_q    <= 1'b0;
    end else if (pix_en) begin
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      video_on_q    <= video_on_d;
      pixel_x_q     <= h_cnt;
      pixel_y_q     <= v_cnt;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      line_irq_q    <= line_irq_d;
    end
  end

  assign h_sync      = h_sync_q;
  assign v_sync      = v_sync_q;
  assign video_on    = video_on_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign line_irq    = line_irq_q;

endmodule
